// File: rtl/regfile_pkg.sv
// regfile_pkg: address-region decode shared by the regfile write decode and read mux.
//   region_e   - class of a register address (ZERO, BTN, SW, EXT, OUT, GP)
//   region_of  - maps an address to its region given the layout parameters
//   layout_ok  - elaboration check that regions are disjoint, skip r0 and fit in NREGS
package regfile_pkg;
  typedef enum logic [2:0] {ZERO, BTN, SW, EXT, OUT, GP} region_e;
  function automatic region_e region_of(input int addr, btn_base, num_btn, sw_base,
                                        ext_base, num_ext, out_base, num_out);
    if (addr == 0) return ZERO;
    if (addr >= btn_base && addr < btn_base + num_btn) return BTN;
    if (addr == sw_base) return SW;
    if (addr >= ext_base && addr < ext_base + num_ext) return EXT;
    if (addr >= out_base && addr < out_base + num_out) return OUT;
    return GP;
  endfunction
  function automatic bit layout_ok(input int nregs, btn_base, num_btn, sw_base,
                                   ext_base, num_ext, out_base, num_out);
    int b [4];
    int n [4];
    b = '{btn_base, sw_base, ext_base, out_base};
    n = '{num_btn, 1, num_ext, num_out};
    for (int i = 0; i < 4; i++) begin
      if (n[i] > 0 && (b[i] < 1 || b[i] + n[i] > nregs)) return 0;
      for (int j = i + 1; j < 4; j++)
        if (n[i] > 0 && n[j] > 0 && b[i] < b[j] + n[j] && b[j] < b[i] + n[i]) return 0;
    end
    return 1;
  endfunction
endpackage

// File: rtl/io_mapped_regfile_btn_debounce.sv
// btn_debounce: one button channel - 2-flop synchroniser, stability counter, level, rise pulse.
//   clk_i   clock            rst_ni  synchronous active-low reset
//   btn_i   raw button       level_o debounced level
//   rise_o  1-cycle pulse in the cycle the level is high for the first time
//   set_o   combinational: the level rises at the coming edge (feeds the sticky flag)
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic set_o
);
  localparam int DEB_W = $clog2(DEB_CYCLES);
  logic s1_q, s2_q, level_q, rise_q, acc;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  assign acc = (s2_q != level_q) && (cnt_q == DEB_W'(DEB_CYCLES - 1));
  assign cnt_d = (s2_q == level_q || acc) ? '0 : cnt_q + 1'b1;
  assign set_o = acc & s2_q;
  assign level_o = level_q;
  assign rise_o = rise_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      cnt_q <= '0;
      level_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      level_q <= acc ? s2_q : level_q;
      rise_q <= set_o;
    end
  end
endmodule

// File: rtl/io_mapped_regfile.sv
// io_mapped_regfile: 2-read/1-write register file with memory-mapped buttons, switches,
// external words and exposed output registers.
//   clock, ctrl_reset_n (sync, active-low)
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg   write port
//   ctrl_readRegA/B -> data_readRegA/B              combinational read ports
//   btn_in, sw_in, ext_in                           board inputs
//   out_regs (r[OUT_BASE..] flat), btn_press (rise pulses), wr_err (read-only write pulse)
// Optional REGFILE_BYPASS_EN: forward write data to a read port addressing the same
// writable register in the same cycle.
module io_mapped_regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_BTN    = 5,
  parameter int BTN_BASE   = 1,
  parameter int SW_W       = 16,
  parameter int SW_BASE    = 6,
  parameter int NUM_EXT    = 2,
  parameter int EXT_BASE   = 8,
  parameter int NUM_OUT    = 5,
  parameter int OUT_BASE   = 11,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                        clock,
  input  logic                        ctrl_reset_n,
  input  logic                        ctrl_writeEnable,
  input  logic [ADDR_W-1:0]           ctrl_writeReg,
  input  logic [DATA_W-1:0]           data_writeReg,
  input  logic [ADDR_W-1:0]           ctrl_readRegA,
  input  logic [ADDR_W-1:0]           ctrl_readRegB,
  output logic [DATA_W-1:0]           data_readRegA,
  output logic [DATA_W-1:0]           data_readRegB,
  input  logic [NUM_BTN-1:0]          btn_in,
  input  logic [SW_W-1:0]             sw_in,
  input  logic [NUM_EXT*DATA_W-1:0]   ext_in,
  output logic [NUM_OUT*DATA_W-1:0]   out_regs,
  output logic [NUM_BTN-1:0]          btn_press,
  output logic                        wr_err
);
  localparam int NREGS = 2 ** ADDR_W;
  if (!layout_ok(NREGS, BTN_BASE, NUM_BTN, SW_BASE, EXT_BASE, NUM_EXT, OUT_BASE, NUM_OUT)) begin : g_bad_layout
    $error("io_mapped_regfile: address regions overlap, include r0 or exceed NREGS-1");
  end
  if (SW_W > DATA_W || DEB_CYCLES < 2) begin : g_bad_param
    $error("io_mapped_regfile: SW_W > DATA_W or DEB_CYCLES < 2");
  end
  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] rd_val [NREGS];
  logic [DATA_W-1:0] ext_q [NUM_EXT];
  logic [SW_W-1:0] sw_s1_q, sw_q;
  logic [NUM_BTN-1:0] level, set, press, sticky_q, sticky_d;
  logic wr_err_q, wr_err_d, wr_ok;
  region_e wr_rg;
  assign wr_rg = region_of(int'(ctrl_writeReg), BTN_BASE, NUM_BTN, SW_BASE, EXT_BASE, NUM_EXT, OUT_BASE, NUM_OUT);
  assign wr_ok = ctrl_writeEnable && (wr_rg == OUT || wr_rg == GP);
  assign wr_err_d = ctrl_writeEnable && (wr_rg == SW || wr_rg == EXT);
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i  (clock),
      .rst_ni (ctrl_reset_n),
      .btn_i  (btn_in[i]),
      .level_o(level[i]),
      .rise_o (press[i]),
      .set_o  (set[i])
    );
    // a rise in the same cycle as a clearing write keeps the flag set
    assign sticky_d[i] = set[i] | (sticky_q[i] & ~(ctrl_writeEnable && ctrl_writeReg == ADDR_W'(BTN_BASE + i)));
  end
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      for (int a = 0; a < NREGS; a++) mem_q[a] <= '0;
      for (int j = 0; j < NUM_EXT; j++) ext_q[j] <= '0;
      sw_s1_q <= '0;
      sw_q <= '0;
      sticky_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      if (wr_ok) mem_q[ctrl_writeReg] <= data_writeReg;
      for (int j = 0; j < NUM_EXT; j++) ext_q[j] <= ext_in[j*DATA_W +: DATA_W];
      sw_s1_q <= sw_in;
      sw_q <= sw_s1_q;
      sticky_q <= sticky_d;
      wr_err_q <= wr_err_d;
    end
  end
  for (genvar a = 0; a < NREGS; a++) begin : g_rd
    localparam region_e RG = region_of(a, BTN_BASE, NUM_BTN, SW_BASE, EXT_BASE, NUM_EXT, OUT_BASE, NUM_OUT);
    if (RG == BTN) begin : g_b
      assign rd_val[a] = DATA_W'({sticky_q[a-BTN_BASE], level[a-BTN_BASE]});
    end else if (RG == SW) begin : g_s
      assign rd_val[a] = DATA_W'(sw_q);
    end else if (RG == EXT) begin : g_e
      assign rd_val[a] = ext_q[a-EXT_BASE];
    end else if (RG == OUT || RG == GP) begin : g_w
      assign rd_val[a] = mem_q[a];
    end else begin : g_z
      assign rd_val[a] = '0;
    end
  end
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign out_regs[k*DATA_W +: DATA_W] = mem_q[OUT_BASE+k];
  end
`ifdef REGFILE_BYPASS_EN
  assign data_readRegA = (wr_ok && ctrl_readRegA == ctrl_writeReg) ? data_writeReg : rd_val[ctrl_readRegA];
  assign data_readRegB = (wr_ok && ctrl_readRegB == ctrl_writeReg) ? data_writeReg : rd_val[ctrl_readRegB];
`else
  assign data_readRegA = rd_val[ctrl_readRegA];
  assign data_readRegB = rd_val[ctrl_readRegB];
`endif
  assign btn_press = press;
  assign wr_err = wr_err_q;
endmodule
